// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with a valid/ready input.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits, then GAP_CYCLES forced idle-high cycles.
// Optional parity is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int GAP_CYCLES   = 20000,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic                 busy,
  output logic                 finish_tx,
  output logic                 uart_tx_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int CW = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic [CW-1:0] BIT_ONE   = CW'(1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  state_t               state_r, state_next;
  logic [BW-1:0]        baud_r, baud_next;
  logic [CW-1:0]        bit_r, bit_next;
  logic [GW-1:0]        gap_r, gap_next;
  logic [DATA_BITS-1:0] shift_r, shift_next;
  logic                 tx_next, ready_next, busy_next, finish_next;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  logic parity_r, parity_next;
`endif

  // Next-state, counter and registered-output logic for the frame sequencer.
  always_comb begin
    state_next  = state_r;
    baud_next   = baud_r;
    bit_next    = bit_r;
    gap_next    = gap_r;
    shift_next  = shift_r;
    tx_next     = uart_tx_o;
    ready_next  = ready_out;
    busy_next   = busy;
    finish_next = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_r;
`endif
    case (state_r)
      S_IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        baud_next = '0;
        bit_next  = '0;
        gap_next  = '0;
        if (valid_in && ready_out) begin
          shift_next = data_in;
          state_next = S_START;
          tx_next    = 1'b0;
          ready_next = 1'b0;
          busy_next  = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_next = (^data_in) ^ PAR_SENSE;
`endif
        end else begin
          ready_next = 1'b1;
        end
      end
      S_START: begin
        if (baud_r == BAUD_LAST) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_DATA;
          tx_next    = shift_r[0];
        end else begin
          baud_next = baud_r + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_next = '0;
          if (bit_r == DATA_LAST) begin
            bit_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
            tx_next    = parity_r;
`else
            state_next = S_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_next   = bit_r + BIT_ONE;
            shift_next = shift_r >> 1;
            tx_next    = shift_r[1];
          end
        end else begin
          baud_next = baud_r + BAUD_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_r == BAUD_LAST) begin
          baud_next  = '0;
          state_next = S_STOP;
          tx_next    = 1'b1;
        end else begin
          baud_next = baud_r + BAUD_ONE;
        end
      end
`endif
      S_STOP: begin
        tx_next = 1'b1;
        // Pulse lands on the final cycle of the last stop bit.
        if ((bit_r == STOP_LAST) && (baud_r == BAUD_PRE)) begin
          finish_next = 1'b1;
        end else begin
          finish_next = 1'b0;
        end
        if (baud_r == BAUD_LAST) begin
          baud_next = '0;
          if (bit_r == STOP_LAST) begin
            bit_next = '0;
            gap_next = '0;
            if (GAP_CYCLES > 0) begin
              state_next = S_GAP;
            end else begin
              state_next = S_IDLE;
              ready_next = 1'b1;
              busy_next  = 1'b0;
            end
          end else begin
            bit_next = bit_r + BIT_ONE;
          end
        end else begin
          baud_next = baud_r + BAUD_ONE;
        end
      end
      S_GAP: begin
        tx_next = 1'b1;
        if (gap_r == GAP_LAST) begin
          gap_next   = '0;
          state_next = S_IDLE;
          ready_next = 1'b1;
          busy_next  = 1'b0;
        end else begin
          gap_next = gap_r + GAP_ONE;
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
        ready_next = 1'b0;
        busy_next  = 1'b0;
        baud_next  = '0;
        bit_next   = '0;
        gap_next   = '0;
      end
    endcase
  end

  // State, counters, shift register and registered outputs; reset aborts any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      baud_r    <= '0;
      bit_r     <= '0;
      gap_r     <= '0;
      shift_r   <= '0;
      uart_tx_o <= 1'b1;
      ready_out <= 1'b0;
      busy      <= 1'b0;
      finish_tx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_next;
      baud_r    <= baud_next;
      bit_r     <= bit_next;
      gap_r     <= gap_next;
      shift_r   <= shift_next;
      uart_tx_o <= tx_next;
      ready_out <= ready_next;
      busy      <= busy_next;
      finish_tx <= finish_next;
`ifdef UART_TX_PARITY_EN
      parity_r  <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg (CLKS_PER_BIT=4).
// dut_a: 8N1 gap 8; dut_b: 8 bits, 2 stop, gap 0; dut_c: 5 bits, gap 8;
// dut_e (parity build only): odd parity.
module tb_uart_tx_cfg;
`ifdef UART_TX_PARITY_EN
  localparam int P  = 1;
  localparam int NI = 4;
`else
  localparam int P  = 0;
  localparam int NI = 3;
`endif
  localparam int C  = 4;
  localparam int GA = 8;
  localparam int FA = (1 + 8 + P + 1) * C;
  localparam int FB = (1 + 8 + P + 2) * C;
  localparam int FC = (1 + 5 + P + 1) * C;

  logic          clk = 1'b0;
  logic [NI-1:0] rst_v;
  logic [NI-1:0] valid_v;
  logic [7:0]    dbus;
  logic [NI-1:0] tx_v, rdy_v, bsy_v, fin_v;

  logic cap_tx  [256];
  logic cap_fin [256];
  logic cap_rdy [256];
  logic cap_bsy [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .GAP_CYCLES(8), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst_v[0]), .data_in(dbus), .valid_in(valid_v[0]),
    .ready_out(rdy_v[0]), .busy(bsy_v[0]), .finish_tx(fin_v[0]), .uart_tx_o(tx_v[0]));

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2), .GAP_CYCLES(0), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst(rst_v[1]), .data_in(dbus), .valid_in(valid_v[1]),
    .ready_out(rdy_v[1]), .busy(bsy_v[1]), .finish_tx(fin_v[1]), .uart_tx_o(tx_v[1]));

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(5), .STOP_BITS(1), .GAP_CYCLES(8), .PARITY_ODD(0)) dut_c (
    .clk(clk), .rst(rst_v[2]), .data_in(dbus[4:0]), .valid_in(valid_v[2]),
    .ready_out(rdy_v[2]), .busy(bsy_v[2]), .finish_tx(fin_v[2]), .uart_tx_o(tx_v[2]));

`ifdef UART_TX_PARITY_EN
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .GAP_CYCLES(8), .PARITY_ODD(1)) dut_e (
    .clk(clk), .rst(rst_v[3]), .data_in(dbus), .valid_in(valid_v[3]),
    .ready_out(rdy_v[3]), .busy(bsy_v[3]), .finish_tx(fin_v[3]), .uart_tx_o(tx_v[3]));
`endif

  // Waits (bounded) for ready, performs one handshake at edge T, then records
  // ncyc cycles T..T+ncyc-1. mode 0: drop valid; 1: hold valid with d2;
  // 2: hold valid with data changing every cycle.
  task automatic run_frame(input int inst, input logic [7:0] d, input int mode,
                           input logic [7:0] d2, input int ncyc, output bit hs_ok);
    int w;
    hs_ok = 1'b0;
    w = 0;
    while (rdy_v[inst] !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (rdy_v[inst] === 1'b1) begin
      hs_ok = 1'b1;
      dbus = d;
      valid_v[inst] = 1'b1;
      @(posedge clk);
      #1;
      if (mode == 0) valid_v[inst] = 1'b0;
      else dbus = d2;
      for (int k = 0; k < ncyc; k++) begin
        @(negedge clk);
        cap_tx[k]  = tx_v[inst];
        cap_fin[k] = fin_v[inst];
        cap_rdy[k] = rdy_v[inst];
        cap_bsy[k] = bsy_v[inst];
        if (mode == 2) dbus = 8'(k * 37 + 1);
      end
      valid_v[inst] = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_checks += 4;
      if (tx_v[i] !== 1'b1) begin n_fail++; $display("FAIL rst_tx inst=%0d got %b exp 1", i, tx_v[i]); end
      if (fin_v[i] !== 1'b0) begin n_fail++; $display("FAIL rst_fin inst=%0d got %b exp 0", i, fin_v[i]); end
      if (bsy_v[i] !== 1'b0) begin n_fail++; $display("FAIL rst_busy inst=%0d got %b exp 0", i, bsy_v[i]); end
      if (rdy_v[i] !== 1'b0) begin n_fail++; $display("FAIL rst_ready inst=%0d got %b exp 0", i, rdy_v[i]); end
    end
    rst_v = '0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_checks += 2;
      if (rdy_v[i] !== 1'b1) begin n_fail++; $display("FAIL rel_ready inst=%0d got %b exp 1", i, rdy_v[i]); end
      if (bsy_v[i] !== 1'b0) begin n_fail++; $display("FAIL rel_busy inst=%0d got %b exp 0", i, bsy_v[i]); end
    end
  endtask

  task automatic test_frame_a5();
    bit ok;
    logic [15:0] fr;
`ifdef UART_TX_PARITY_EN
    fr = 16'({1'b1, 1'b0, 8'hA5, 1'b0});
`else
    fr = 16'({1'b1, 8'hA5, 1'b0});
`endif
    run_frame(0, 8'hA5, 0, 8'h00, FA + GA + 1, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL a5_handshake got %b exp 1", ok); end
    for (int k = 0; k <= FA + GA; k++) begin
      n_checks += 4;
      if (cap_tx[k] !== ((k < FA) ? fr[k / C] : 1'b1)) begin n_fail++; $display("FAIL a5_line k=%0d got %b", k, cap_tx[k]); end
      if (cap_fin[k] !== (k == FA - 1)) begin n_fail++; $display("FAIL a5_finish k=%0d got %b", k, cap_fin[k]); end
      if (cap_rdy[k] !== (k == FA + GA)) begin n_fail++; $display("FAIL a5_ready k=%0d got %b", k, cap_rdy[k]); end
      if (cap_bsy[k] !== (k < FA + GA)) begin n_fail++; $display("FAIL a5_busy k=%0d got %b", k, cap_bsy[k]); end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity_odd();
    bit ok;
    logic [15:0] fr;
    fr = 16'({1'b1, 1'b1, 8'hA5, 1'b0});
    run_frame(3, 8'hA5, 0, 8'h00, FA + GA + 1, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL odd_handshake got %b exp 1", ok); end
    for (int k = 0; k <= FA + GA; k++) begin
      n_checks += 2;
      if (cap_tx[k] !== ((k < FA) ? fr[k / C] : 1'b1)) begin n_fail++; $display("FAIL odd_line k=%0d got %b", k, cap_tx[k]); end
      if (cap_fin[k] !== (k == 43)) begin n_fail++; $display("FAIL odd_finish k=%0d got %b", k, cap_fin[k]); end
    end
  endtask
`endif

  task automatic test_hold_valid();
    bit ok;
    logic [15:0] fr;
`ifdef UART_TX_PARITY_EN
    fr = 16'({1'b1, 1'b0, 8'h5A, 1'b0});
`else
    fr = 16'({1'b1, 8'h5A, 1'b0});
`endif
    run_frame(0, 8'h5A, 2, 8'hFF, FA + GA + 1, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL hold_handshake got %b exp 1", ok); end
    for (int k = 0; k <= FA + GA; k++) begin
      n_checks += 3;
      if (cap_tx[k] !== ((k < FA) ? fr[k / C] : 1'b1)) begin n_fail++; $display("FAIL hold_line k=%0d got %b", k, cap_tx[k]); end
      if (cap_rdy[k] !== (k == FA + GA)) begin n_fail++; $display("FAIL hold_ready k=%0d got %b", k, cap_rdy[k]); end
      if (cap_bsy[k] !== (k < FA + GA)) begin n_fail++; $display("FAIL hold_busy k=%0d got %b", k, cap_bsy[k]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [15:0] f1, f2;
    logic exp_tx;
`ifdef UART_TX_PARITY_EN
    f1 = 16'({2'b11, 1'b0, 8'h00, 1'b0});
    f2 = 16'({2'b11, 1'b0, 8'hFF, 1'b0});
`else
    f1 = 16'({2'b11, 8'h00, 1'b0});
    f2 = 16'({2'b11, 8'hFF, 1'b0});
`endif
    run_frame(1, 8'h00, 1, 8'hFF, 2 * FB + 1, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_handshake got %b exp 1", ok); end
    for (int k = 0; k <= 2 * FB; k++) begin
      if (k < FB) exp_tx = f1[k / C];
      else if (k == FB) exp_tx = 1'b1;
      else exp_tx = f2[(k - FB - 1) / C];
      n_checks += 4;
      if (cap_tx[k] !== exp_tx) begin n_fail++; $display("FAIL b2b_line k=%0d got %b exp %b", k, cap_tx[k], exp_tx); end
      if (cap_fin[k] !== ((k == FB - 1) || (k == 2 * FB))) begin n_fail++; $display("FAIL b2b_finish k=%0d got %b", k, cap_fin[k]); end
      if (cap_rdy[k] !== (k == FB)) begin n_fail++; $display("FAIL b2b_ready k=%0d got %b", k, cap_rdy[k]); end
      if (cap_bsy[k] !== (k != FB)) begin n_fail++; $display("FAIL b2b_busy k=%0d got %b", k, cap_bsy[k]); end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int fin_seen;
    int tx_low;
    logic [15:0] fr;
    run_frame(0, 8'h00, 0, 8'h00, 15, ok);
    n_checks += 2;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_handshake got %b exp 1", ok); end
    if (cap_tx[14] !== 1'b0) begin n_fail++; $display("FAIL mid_line_before got %b exp 0", cap_tx[14]); end
    @(posedge clk);
    #1;
    rst_v[0] = 1'b1;
    #1;
    n_checks += 3;
    if (tx_v[0] !== 1'b1) begin n_fail++; $display("FAIL mid_rst_tx got %b exp 1", tx_v[0]); end
    if (bsy_v[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b exp 0", bsy_v[0]); end
    if (rdy_v[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready got %b exp 0", rdy_v[0]); end
    fin_seen = 0;
    tx_low = 0;
    repeat (2) begin
      @(negedge clk);
      if (fin_v[0] !== 1'b0) fin_seen++;
      if (tx_v[0] !== 1'b1) tx_low++;
    end
    rst_v[0] = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (fin_v[0] !== 1'b0) fin_seen++;
      if (tx_v[0] !== 1'b1) tx_low++;
    end
    n_checks += 2;
    if (fin_seen !== 0) begin n_fail++; $display("FAIL mid_no_finish got %0d pulses exp 0", fin_seen); end
    if (tx_low !== 0) begin n_fail++; $display("FAIL mid_line_idle got %0d low cycles exp 0", tx_low); end
`ifdef UART_TX_PARITY_EN
    fr = 16'({1'b1, 1'b0, 8'h3C, 1'b0});
`else
    fr = 16'({1'b1, 8'h3C, 1'b0});
`endif
    run_frame(0, 8'h3C, 0, 8'h00, FA + GA + 1, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL post_handshake got %b exp 1", ok); end
    for (int k = 0; k <= FA + GA; k++) begin
      n_checks += 3;
      if (cap_tx[k] !== ((k < FA) ? fr[k / C] : 1'b1)) begin n_fail++; $display("FAIL post_line k=%0d got %b", k, cap_tx[k]); end
      if (cap_fin[k] !== (k == FA - 1)) begin n_fail++; $display("FAIL post_finish k=%0d got %b", k, cap_fin[k]); end
      if (cap_rdy[k] !== (k == FA + GA)) begin n_fail++; $display("FAIL post_ready k=%0d got %b", k, cap_rdy[k]); end
    end
  endtask

  task automatic test_data5();
    bit ok;
    logic [15:0] fr;
`ifdef UART_TX_PARITY_EN
    fr = 16'({1'b1, 1'b1, 5'h13, 1'b0});
`else
    fr = 16'({1'b1, 5'h13, 1'b0});
`endif
    run_frame(2, 8'h13, 0, 8'h00, FC + GA + 1, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL d5_handshake got %b exp 1", ok); end
    for (int k = 0; k <= FC + GA; k++) begin
      n_checks += 3;
      if (cap_tx[k] !== ((k < FC) ? fr[k / C] : 1'b1)) begin n_fail++; $display("FAIL d5_line k=%0d got %b", k, cap_tx[k]); end
      if (cap_fin[k] !== (k == FC - 1)) begin n_fail++; $display("FAIL d5_finish k=%0d got %b", k, cap_fin[k]); end
      if (cap_rdy[k] !== (k == FC + GA)) begin n_fail++; $display("FAIL d5_ready k=%0d got %b", k, cap_rdy[k]); end
    end
  endtask

  initial begin
    rst_v   = '1;
    valid_v = '0;
    dbus    = 8'h00;
    test_reset();
    test_frame_a5();
`ifdef UART_TX_PARITY_EN
    test_parity_odd();
`endif
    test_hold_valid();
    test_back_to_back();
    test_reset_midframe();
    test_data5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter: the successor to the fixed 8N1 byte transmitter in the UART path of the baseband processor. Serialises one word per valid/ready handshake, with configurable baud divider, data width, stop bits and inter-frame gap, plus optional parity. It sits between the TX byte source (packetiser/FIFO) and the board-level TX pin, and signals completion with a one-cycle pulse.

## Interface
- `CLKS_PER_BIT`, default 10417: clock cycles per bit period; legal ≥ 2.
- `DATA_BITS`, default 8: data width; legal 5–9.
- `STOP_BITS`, default 1: number of stop bits; legal 1 or 2.
- `GAP_CYCLES`, default 20000: idle-high cycles forced after each frame; 0 is legal.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Only used when the parity macro is defined.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  DATA_BITS  word to send; sampled at handshake.
- `valid_in`  in  1  source has a word.
- `ready_out`  out  1  block can accept a word. Registered; high only in IDLE.
- `busy`  out  1  high from acceptance until return to IDLE, including the gap.
- `finish_tx`  out  1  one-cycle pulse when the last stop bit completes.
- `uart_tx_o`  out  1  serial line; idles high.

## Operation
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP, GAP.
- IDLE:
  - `ready_out`=1 and `uart_tx_o`=1.
  - Handshake is `valid_in & ready_out` at a rising edge.
  - On handshake: latch `data_in` into the shift register, go to START, drive `uart_tx_o`=0, clear `ready_out`, set `busy`.
- START: line 0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Shift out DATA_BITS bits, LSB first, CLKS_PER_BIT cycles each.
  - A bit counter counts to DATA_BITS-1.
  - Next state is PARITY if compiled in, otherwise STOP.
- PARITY: XOR of the latched word (inverted when PARITY_ODD=1) for one bit period, then STOP.
- STOP:
  - Line 1 for STOP_BITS×CLKS_PER_BIT cycles.
  - On the last cycle, `finish_tx` is registered high for exactly one cycle.
  - Next state is GAP if GAP_CYCLES>0, otherwise IDLE.
- GAP: line 1 and `ready_out`=0 for GAP_CYCLES cycles, then IDLE.
- Handshake and input rules:
  - `valid_in` outside IDLE is ignored; no word is queued.
  - Changes to `data_in` after the handshake do not affect the frame in flight.
- Counter widths:
  - Baud counter is $clog2(CLKS_PER_BIT) bits.
  - Gap counter is $clog2(GAP_CYCLES+1) bits, minimum 1.
  - Counters reset to 0 at every bit or state boundary and never wrap mid-period.
- Reset values (asynchronous, immediate):
  - `uart_tx_o`=1, `finish_tx`=0, `busy`=0, `ready_out`=0.
  - State=IDLE; all counters and the shift register = 0.
- Reset mid-frame aborts the frame; the line returns high immediately.
- Back-to-back: with GAP_CYCLES=0 and `valid_in` held high, the next start bit begins on the cycle after `ready_out` rises.

## Timing
- Handshake edge T: `uart_tx_o` falls at T; there is no additional latency.
- Frame length F = (1 + DATA_BITS + P + STOP_BITS)×CLKS_PER_BIT cycles, where P=1 with parity, else 0.
- `finish_tx` is high during cycle T+F-1. `uart_tx_o` remains 1 from T+F onward.
- `ready_out` rises at edge T+F+GAP_CYCLES. `busy` falls at the same edge.
- After reset release: `ready_out` rises on the first clock edge. A handshake is possible on the second edge.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state is compiled in, one parity bit is inserted after the data bits, and PARITY_ODD selects its sense.
- Undefined: no PARITY state and no parity logic. Frames are DATA_BITS-N-STOP_BITS and PARITY_ODD is ignored.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, GAP_CYCLES=8, no parity unless stated.
- Send 0xA5:
  - Line reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
  - `finish_tx` pulses once at T+39.
  - `ready_out` rises at T+48.
- Parity build, send 0xA5:
  - PARITY_ODD=0: parity bit=0.
  - PARITY_ODD=1: parity bit=1.
  - Frame is 44 cycles and `finish_tx` pulses at T+43.
- Hold `valid_in` high with changing `data_in` during the frame:
  - The frame carries only the first word, and no second handshake occurs before T+48.
- GAP_CYCLES=0, STOP_BITS=2, `valid_in` held high with 0x00 then 0xFF:
  - Each frame is 44 cycles.
  - The second start bit begins at T+45.
- Assert `rst` at cycle 15 of a frame:
  - `uart_tx_o`=1 and `busy`=0 immediately; `finish_tx` never pulses.
  - After release, a new 0x3C frame transmits correctly.
- DATA_BITS=5, send 0x13:
  - Line reads 0,1,1,0,0,1,1, for a 28-cycle frame.
